// File: rtl/sram_port_arbiter.sv
// Two-master round-robin arbiter in front of one SRAM port, with a one-stage
// read-response pipeline that tags data and range errors back to the issuing master.
module sram_port_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_req,
    output logic                 m0_gnt,
    input  logic [31:0]          m0_addr,
    input  logic                 m0_we,
    input  logic [3:0]           m0_be,
    input  logic [DATAWIDTH-1:0] m0_wdata,
    output logic                 m0_rvalid,
    output logic [DATAWIDTH-1:0] m0_rdata,
    output logic                 m0_err,

    input  logic                 m1_req,
    output logic                 m1_gnt,
    input  logic [31:0]          m1_addr,
    input  logic                 m1_we,
    input  logic [3:0]           m1_be,
    input  logic [DATAWIDTH-1:0] m1_wdata,
    output logic                 m1_rvalid,
    output logic [DATAWIDTH-1:0] m1_rdata,
    output logic                 m1_err,

    output logic [ADDRWIDTH-1:0] sram_addr,
    output logic                 sram_we,
    output logic [3:0]           sram_be,
    output logic [DATAWIDTH-1:0] sram_d,
    input  logic [DATAWIDTH-1:0] sram_q
);

    // last_grant = 1 means m1 won the most recent handshake
    logic                 last_grant;
    logic                 gnt0;
    logic                 gnt1;
    logic                 any_gnt;
    logic                 sel;

    logic                 oor0;
    logic                 oor1;

    logic [31:0]          sel_addr;
    logic                 sel_we;
    logic [3:0]           sel_be;
    logic [DATAWIDTH-1:0] sel_wdata;
    logic                 sel_oor;

    logic                 resp_valid;
    logic                 resp_owner;
    logic                 resp_read;
    logic                 resp_err;

    logic                 rv0;
    logic                 rv1;
    logic                 unused_addr_bits;

    assign oor0 = |m0_addr[31:ADDRWIDTH+2];
    assign oor1 = |m1_addr[31:ADDRWIDTH+2];

    always_comb begin
        gnt0 = m0_req & (~m1_req | last_grant);
        gnt1 = m1_req & (~m0_req | ~last_grant);
    end

    assign any_gnt = gnt0 | gnt1;
    assign m0_gnt  = gnt0;
    assign m1_gnt  = gnt1;

    // With no grant the mux stays on the last winner so sram_addr does not toggle
    assign sel = any_gnt ? gnt1 : last_grant;

    always_comb begin
        sel_addr  = m0_addr;
        sel_we    = m0_we;
        sel_be    = m0_be;
        sel_wdata = m0_wdata;
        sel_oor   = oor0;
        if (sel) begin
            sel_addr  = m1_addr;
            sel_we    = m1_we;
            sel_be    = m1_be;
            sel_wdata = m1_wdata;
            sel_oor   = oor1;
        end
    end

    assign sram_addr = sel_addr[ADDRWIDTH+1:2];
    assign sram_we   = any_gnt & sel_we & ~sel_oor;
    assign sram_be   = any_gnt ? sel_be : 4'b0000;
    assign sram_d    = sel_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
            resp_read  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (any_gnt) begin
                last_grant <= gnt1;
            end
            // In-range writes complete silently; everything else gets a response slot
            resp_valid <= any_gnt & (~sel_we | sel_oor);
            resp_owner <= sel;
            resp_read  <= ~sel_we;
            resp_err   <= sel_oor;
        end
    end

    assign rv0 = resp_valid & resp_read & ~resp_owner;
    assign rv1 = resp_valid & resp_read &  resp_owner;

    assign m0_rvalid = rv0;
    assign m1_rvalid = rv1;
    assign m0_rdata  = (rv0 & ~resp_err) ? sram_q : '0;
    assign m1_rdata  = (rv1 & ~resp_err) ? sram_q : '0;
    assign m0_err    = resp_valid & resp_err & ~resp_owner;
    assign m1_err    = resp_valid & resp_err &  resp_owner;

    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0], sel_addr[1:0]};

endmodule
